// File: rtl/multisim_push_packer.sv
// Packs narrow input beats LSB-first into one wide word for the multisim push server.
// A word is emitted when full, on in_last, or after TIMEOUT idle cycles with a partial word pending.
module multisim_push_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 8,
  parameter int TIMEOUT  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [IN_WIDTH-1:0]          in_data,
  input  logic                         in_last,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [IN_WIDTH*RATIO-1:0]    out_data,
  output logic [$clog2(RATIO+1)-1:0]   out_count
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CNT_W     = $clog2(RATIO + 1);
  localparam int ACC_W     = $clog2(RATIO);
  localparam int IDLE_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ACC_W-1:0]  LAST_LANE = ACC_W'(RATIO - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_W-1:0]     acc_cnt_q, acc_cnt_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic                 out_vld_q, out_vld_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]     out_count_q, out_count_d;

  logic                 slot_free;
  logic                 accept;
  logic                 complete;
  logic                 flush;
  logic [OUT_WIDTH-1:0] merged;

  // Slot counts as free when the current word drains this very cycle.
  assign slot_free = !out_vld_q || out_rdy;
  assign in_rdy    = slot_free;
  assign accept    = in_vld && slot_free;
  assign complete  = accept && ((acc_cnt_q == LAST_LANE) || in_last);
  assign flush     = (TIMEOUT > 0) && !accept && (idle_q == IDLE_MAX)
                     && (acc_cnt_q != '0) && slot_free;

  // Accumulator with the incoming beat dropped into its lane; upper lanes stay zero.
  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      assign merged[gi*IN_WIDTH +: IN_WIDTH] =
        (accept && (acc_cnt_q == ACC_W'(gi))) ? in_data : acc_q[gi*IN_WIDTH +: IN_WIDTH];
    end
  endgenerate

  always_comb begin
    acc_d       = acc_q;
    acc_cnt_d   = acc_cnt_q;
    idle_d      = idle_q;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;

    if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end

    if (complete || flush) begin
      acc_d       = '0;
      acc_cnt_d   = '0;
      out_vld_d   = 1'b1;
      out_data_d  = merged;
      out_count_d = complete ? (CNT_W'(acc_cnt_q) + CNT_W'(1)) : CNT_W'(acc_cnt_q);
    end else if (accept) begin
      acc_d     = merged;
      acc_cnt_d = acc_cnt_q + ACC_W'(1);
    end

    // Idle time only accrues while a partial word is waiting for more beats.
    if (accept || flush || (acc_cnt_q == '0)) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      idle_q      <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      idle_q      <= idle_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_vld   = out_vld_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_multisim_push_packer.sv
// Scoreboard bench for multisim_push_packer (IN_WIDTH=8, RATIO=4, TIMEOUT=5).
// Stimulus pushes hand-computed words; the monitor pops and compares on every output transfer.
module tb_multisim_push_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_count;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   xfers  = 0;

  multisim_push_packer #(.IN_WIDTH(8), .RATIO(4), .TIMEOUT(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: one line per output transfer, compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_vld && out_rdy) begin
      xfers++;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got data=0x%08h count=%0d, expected no word", out_data, out_count);
      end else begin
        mon_e = sb.pop_front();
        $display("xfer data=0x%08h count=%0d (expected 0x%08h/%0d)", out_data, out_count, mon_e.data, mon_e.cnt);
        chk("word_data", out_data, mon_e.data);
        chk("word_count", {29'b0, out_count}, {29'b0, mon_e.cnt});
      end
    end
  end

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send(input logic [7:0] d, input logic last, output int waits);
    bit got;
    got     = 1'b0;
    waits   = 0;
    in_vld  = 1'b1;
    in_data = d;
    in_last = last;
    while (!got && waits < 50) begin
      @(negedge clk);
      got = in_rdy;
      @(posedge clk);
      #1;
      waits++;
    end
    if (!got) begin
      checks++;
      $display("FAIL send_timeout: beat 0x%02h not accepted, got in_rdy=0, expected 1 within 50 cycles", d);
    end
    in_last = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] first, input int n);
    int w;
    for (int i = 0; i < n; i++) send(first + 8'(i), 1'b0, w);
  endtask

  // Word must appear exactly 6 cycles after the last accepted beat.
  task automatic expect_flush(input string name, input logic [31:0] data);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      chk({name, "_quiet"}, {31'b0, out_vld}, 32'd0);
    end
    @(posedge clk);
    #1;
    chk({name, "_vld"}, {31'b0, out_vld}, 32'd1);
    chk({name, "_data"}, out_data, data);
  endtask

  task automatic async_reset(input string name);
    in_vld = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({name, "_vld"}, {31'b0, out_vld}, 32'd0);
    chk({name, "_data"}, out_data, 32'd0);
    chk({name, "_count"}, {29'b0, out_count}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int w;
    int x0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_vld", {31'b0, out_vld}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_count", {29'b0, out_count}, 32'd0);
    chk("rst_in_rdy", {31'b0, in_rdy}, 32'd1);

    // Full word, one-cycle latency, single-cycle valid.
    out_rdy = 1'b1;
    sb.push_back(exp_t'{32'h44332211, 3'd4});
    send(8'h11, 1'b0, w); send(8'h22, 1'b0, w); send(8'h33, 1'b0, w); send(8'h44, 1'b0, w);
    in_vld = 1'b0;
    chk("full_vld", {31'b0, out_vld}, 32'd1);
    chk("full_data", out_data, 32'h44332211);
    chk("full_count", {29'b0, out_count}, 32'd4);
    @(posedge clk);
    #1 chk("full_vld_drop", {31'b0, out_vld}, 32'd0);

    // in_last flushes a partial word; packing resumes at lane 0.
    sb.push_back(exp_t'{32'h0000B2A1, 3'd2});
    sb.push_back(exp_t'{32'h04030201, 3'd4});
    send(8'hA1, 1'b0, w); send(8'hB2, 1'b1, w);
    send_seq(8'h01, 4);
    in_vld = 1'b0;
    @(posedge clk);
    #1;

    // Back-pressure: first word holds, in_rdy drops, nothing lost on release.
    out_rdy = 1'b0;
    sb.push_back(exp_t'{32'h04030201, 3'd4});
    sb.push_back(exp_t'{32'h08070605, 3'd4});
    send_seq(8'h01, 4);
    in_vld  = 1'b1;
    in_data = 8'h05;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_rdy", {31'b0, in_rdy}, 32'd0);
      chk("stall_vld", {31'b0, out_vld}, 32'd1);
      chk("stall_data", out_data, 32'h04030201);
      chk("stall_count", {29'b0, out_count}, 32'd4);
      @(posedge clk);
      #1;
    end
    out_rdy = 1'b1;
    send_seq(8'h05, 4);
    in_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Idle timeout on a single beat, then a beat at idle=4 restarting the count.
    sb.push_back(exp_t'{32'h0000007E, 3'd1});
    send(8'h7E, 1'b0, w);
    in_vld = 1'b0;
    expect_flush("timeout1", 32'h0000007E);
    @(posedge clk);
    #1;
    sb.push_back(exp_t'{32'h00002010, 3'd2});
    send(8'h10, 1'b0, w);
    in_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send(8'h20, 1'b0, w);
    in_vld = 1'b0;
    chk("timeout_restart_vld", {31'b0, out_vld}, 32'd0);
    expect_flush("timeout2", 32'h00002010);
    @(posedge clk);
    #1;

    // Back-to-back stream: in_rdy never drops, exactly three words.
    sb.push_back(exp_t'{32'h04030201, 3'd4});
    sb.push_back(exp_t'{32'h08070605, 3'd4});
    sb.push_back(exp_t'{32'h0C0B0A09, 3'd4});
    x0 = xfers;
    for (int i = 1; i <= 12; i++) begin
      send(8'(i), 1'b0, w);
      chk("b2b_first_try", w, 32'd1);
    end
    in_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("b2b_word_count", xfers - x0, 32'd3);

    // Async reset with a held word, then with a partial word accumulated.
    out_rdy = 1'b0;
    send_seq(8'h01, 4);
    in_vld = 1'b0;
    chk("pre_reset_vld", {31'b0, out_vld}, 32'd1);
    async_reset("reset_held");
    out_rdy = 1'b1;
    send(8'h55, 1'b0, w); send(8'h66, 1'b0, w);
    in_vld = 1'b0;
    async_reset("reset_partial");
    repeat (8) @(posedge clk);
    #1 chk("post_reset_quiet", {31'b0, out_vld}, 32'd0);
    sb.push_back(exp_t'{32'h04030201, 3'd4});
    send_seq(8'h01, 4);
    in_vld = 1'b0;

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1 chk("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
